mem_arbiter: RTL

Two-requester arbiter that shares one single-ported memory bus between the instruction-fetch stage (IF port) and the MEM stage load/store path (DM port). It sits between the pipeline and the memory/mmio subsystem, replacing the separate combinational rom/mmio accesses once memory becomes unified and variable-latency. It runs one transaction at a time and uses round-robin priority on ties. It returns registered responses to the owning requester and supports killing an in-flight fetch on a pipeline flush.

---
 rtl/mem_arbiter_pkg.sv | 23 ++
 rtl/mem_arbiter_rr_arb2.sv | 23 ++
 rtl/mem_arbiter.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the IF/DM memory bus arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

  localparam int unsigned DataWidthDefault = 64;
  localparam int unsigned MaskWidth        = DataWidthDefault / 8;

  function automatic int unsigned mask_width(input int unsigned dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick between the fetch and data requesters.
module rr_arb2
  import mem_arbiter_pkg::*;
(
  input  logic   i_req_if,
  input  logic   i_req_dm,
  input  owner_t i_last,
  output logic   o_any,
  output owner_t o_owner
);

  always_comb begin
    o_any = i_req_if | i_req_dm;
    if (i_req_if && i_req_dm) begin
      o_owner = (i_last == OWN_IF) ? OWN_DM : OWN_IF;
    end else if (i_req_dm) begin
      o_owner = OWN_DM;
    end else begin
      o_owner = OWN_IF;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-ported memory bus between instruction fetch and data memory,
// one transaction at a time, with round-robin tie breaking and fetch kill.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  input  logic                    if_kill,
  output logic                    if_gnt,
  output logic                    if_valid,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  input  logic                    dm_req,
  input  logic                    dm_we,
  input  logic [ADDR_WIDTH-1:0]   dm_addr,
  input  logic [DATA_WIDTH-1:0]   dm_wdata,
  input  logic [DATA_WIDTH/8-1:0] dm_wmask,
  output logic                    dm_gnt,
  output logic                    dm_valid,
  output logic [DATA_WIDTH-1:0]   dm_rdata,
  output logic                    bus_req,
  output logic                    bus_we,
  output logic [ADDR_WIDTH-1:0]   bus_addr,
  output logic [DATA_WIDTH-1:0]   bus_wdata,
  output logic [DATA_WIDTH/8-1:0] bus_wmask,
  input  logic                    bus_gnt,
  input  logic                    bus_rvalid,
  input  logic [DATA_WIDTH-1:0]   bus_rdata
);

  localparam int unsigned MW = mask_width(DATA_WIDTH);

  state_t                r_state;
  owner_t                r_owner;
  owner_t                r_last;
  logic                  r_kill;
  logic                  r_if_valid;
  logic                  r_dm_valid;
  logic [DATA_WIDTH-1:0] r_if_rdata;
  logic [DATA_WIDTH-1:0] r_dm_rdata;
  logic                  r_bus_we;
  logic [ADDR_WIDTH-1:0] r_bus_addr;
  logic [DATA_WIDTH-1:0] r_bus_wdata;
  logic [MW-1:0]         r_bus_wmask;

  logic   w_any;
  owner_t w_pick;
  logic   w_gnt;
  logic   w_if_kill;

  rr_arb2 u_rr_arb2 (
    .i_req_if (if_req),
    .i_req_dm (dm_req),
    .i_last   (r_last),
    .o_any    (w_any),
    .o_owner  (w_pick)
  );

  assign w_gnt     = (r_state == REQ) && bus_gnt;
  assign w_if_kill = if_kill && (r_owner == OWN_IF) && (r_state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_owner     <= OWN_IF;
      r_last      <= OWN_IF;
      r_kill      <= 1'b0;
      r_if_valid  <= 1'b0;
      r_dm_valid  <= 1'b0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_bus_wmask <= '0;
    end else begin
      r_if_valid <= 1'b0;
      r_dm_valid <= 1'b0;
      if (w_if_kill) begin
        r_kill <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          r_kill <= 1'b0;
          if (w_any) begin
            r_owner <= w_pick;
            r_state <= REQ;
            if (w_pick == OWN_DM) begin
              r_bus_we    <= dm_we;
              r_bus_addr  <= dm_addr;
              r_bus_wdata <= dm_wdata;
              r_bus_wmask <= dm_wmask;
            end else begin
              r_bus_we    <= 1'b0;
              r_bus_addr  <= if_addr;
              r_bus_wdata <= '0;
              r_bus_wmask <= '0;
            end
          end
        end
        REQ: begin
          if (bus_gnt) begin
            r_last  <= r_owner;
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (bus_rvalid) begin
            r_state <= RESP;
            if (r_owner == OWN_DM) begin
              r_dm_rdata <= r_bus_we ? '0 : bus_rdata;
              r_dm_valid <= 1'b1;
            end else if (!(r_kill || w_if_kill)) begin
              // a kill landing on the response cycle still discards the data
              r_if_rdata <= bus_rdata;
              r_if_valid <= 1'b1;
            end
          end
        end
        RESP: begin
          r_kill  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus_req   = (r_state == REQ);
  assign bus_we    = r_bus_we;
  assign bus_addr  = r_bus_addr;
  assign bus_wdata = r_bus_wdata;
  assign bus_wmask = r_bus_wmask;
  assign if_gnt    = w_gnt && (r_owner == OWN_IF);
  assign dm_gnt    = w_gnt && (r_owner == OWN_DM);
  assign if_valid  = r_if_valid;
  assign dm_valid  = r_dm_valid;
  assign if_rdata  = r_if_rdata;
  assign dm_rdata  = r_dm_rdata;

endmodule
